// File: rtl/seq_sreg_nb_seq.sv
// Sequenced shift/rotate register: parallel load plus a 1..WIDTH step shift engine
// with a busy/done handshake for a controlling FSM.
//
// state  | meaning
// S_IDLE | waiting for ld or start; pout/sout hold
// S_RUN  | applying one step per clock until the counter expires
module seq_sreg_nb_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic             sin,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);
    localparam logic [AW-1:0] ONE     = AW'(1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [AW-1:0]    amt_clamped;
    logic [WIDTH-1:0] step_r;
    logic             step_so;

    assign amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;

    // One single-bit step of the latched mode; the reserved code holds everything.
    always_comb begin
        step_r  = r_q;
        step_so = sout_q;
        case (op_q)
            3'b000: begin step_r = {r_q[WIDTH-2:0], 1'b0};       step_so = r_q[WIDTH-1]; end
            3'b001: begin step_r = {1'b0, r_q[WIDTH-1:1]};       step_so = r_q[0];       end
            3'b010: begin step_r = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; step_so = r_q[0];     end
            3'b011: begin step_r = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; step_so = r_q[WIDTH-1]; end
            3'b100: begin step_r = {r_q[0], r_q[WIDTH-1:1]};     step_so = r_q[0];       end
            3'b101: begin step_r = {r_q[WIDTH-2:0], sin};        step_so = r_q[WIDTH-1]; end
            3'b110: begin step_r = {sin, r_q[WIDTH-1:1]};        step_so = r_q[0];       end
            default: begin step_r = r_q;                         step_so = sout_q;       end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        r_d     = r_q;
        sout_d  = sout_q;
        done_d  = 1'b0;

        if (ld) begin
            // Load aborts any running sequence silently; sout keeps its last value.
            r_d     = pin;
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                if (amt_clamped == '0) begin
                    done_d = 1'b1;
                end else begin
                    op_d    = op;
                    cnt_d   = amt_clamped;
                    state_d = S_RUN;
                end
            end
        end else begin
            r_d    = step_r;
            sout_d = step_so;
            cnt_d  = cnt_q - ONE;
            if (cnt_q == ONE) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            r_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            r_q     <= r_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign pout = r_q;
    assign sout = sout_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_seq_sreg_nb_seq.sv
// Bench for seq_sreg_nb_seq (WIDTH=8): closed-form shift model feeding a scoreboard
// that a done-driven monitor drains, plus directed abort/collision/reset cases.
module tb_seq_sreg_nb_seq;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          ld = 1'b0;
    logic [W-1:0]  pin = '0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [AW-1:0] amt = '0;
    logic          sin = 1'b0;
    logic [W-1:0]  pout;
    logic          sout;
    logic          busy;
    logic          done;

    seq_sreg_nb_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .ld(ld), .pin(pin), .start(start),
        .op(op), .amt(amt), .sin(sin), .pout(pout), .sout(sout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p;
        logic         s;
        int           c;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [W-1:0] mr = '0;
    logic         ms = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Result of n steps computed directly from shift arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] r, input logic so_in,
                                         input int o, input int n, input logic [W-1:0] sins);
        int unsigned rr, m, res, so, s;
        rr = r; m = (1 << W) - 1; res = rr; so = so_in; s = 0;
        if (n == 0 || o == 7) return {so_in, r};
        case (o)
            0: begin res = (rr << n) & m; so = (rr >> (W - n)) & 1; end
            1: begin res = rr >> n;       so = (rr >> (n - 1)) & 1; end
            2: begin
                res = rr >> n;
                if (rr[W-1]) res = res | (m & ~(m >> n));
                so = (rr >> (n - 1)) & 1;
            end
            3: begin res = ((rr << n) | (rr >> (W - n))) & m; so = res & 1; end
            4: begin res = ((rr >> n) | (rr << (W - n))) & m; so = (res >> (W - 1)) & 1; end
            5: begin
                for (int i = 0; i < n; i++) s = s | (int'(sins[i]) << (n - 1 - i));
                res = ((rr << n) | s) & m; so = (rr >> (W - n)) & 1;
            end
            default: begin
                for (int i = 0; i < n; i++) s = s | (int'(sins[i]) << i);
                res = ((rr >> n) | (s << (W - n))) & m; so = (rr >> (n - 1)) & 1;
            end
        endcase
        return {so[0], res[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            check("done_has_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("done_pout", pout, mon_e.p);
                check("done_sout", sout, mon_e.s);
                check("done_cycle", cyc, mon_e.c);
            end
        end
    end

    // All driver tasks begin and end just after a falling edge.
    task automatic do_ld(input logic [W-1:0] v);
        ld = 1'b1; pin = v;
        @(posedge clk); #1;
        check("ld_pout", pout, v);
        check("ld_busy", busy, 0);
        check("ld_sout", sout, ms);
        @(negedge clk);
        ld = 1'b0;
        mr = v;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_seq(input logic [2:0] o, input logic [AW-1:0] a,
                          input logic [W-1:0] sins, input bit poke);
        int n;
        logic [W:0] e;
        n = (a > W) ? W : int'(a);
        check("hold_pout", pout, mr);
        check("hold_sout", sout, ms);
        e = model(mr, ms, int'(o), n, sins);
        sb.push_back('{p: e[W-1:0], s: e[W], c: cyc + 1 + n});
        op = o; amt = a; start = 1'b1;
        @(posedge clk); #1;
        check("busy_t0", busy, (n > 0) ? 1 : 0);
        check("pout_t0", pout, mr);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0; sin = sins[k];
            check("busy_run", busy, 1);
            if (poke && k == 1) begin
                start = 1'b1; op = 3'($urandom); amt = AW'($urandom_range(1, W));
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_done_cycle", busy, 0);
        mr = e[W-1:0]; ms = e[W];
    endtask

    task automatic do_abort(input logic [2:0] o, input logic [AW-1:0] a, input int kld,
                            input logic [W-1:0] v);
        logic [W-1:0] sins;
        logic [W:0]   e;
        sins = W'($urandom);
        e = model(mr, ms, int'(o), kld - 1, sins);
        op = o; amt = a; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < kld; k++) begin
            @(negedge clk);
            start = 1'b0; sin = sins[k];
            if (k == kld - 1) begin ld = 1'b1; pin = v; end
            @(posedge clk);
        end
        #1;
        check("abort_pout", pout, v);
        check("abort_busy", busy, 0);
        check("abort_sout", sout, e[W]);
        @(negedge clk);
        ld = 1'b0;
        mr = v; ms = e[W];
        idle(W + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_pout", pout, 0);
        check("rst_sout", sout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        do_ld(8'hA5);
        check("ld_sout_after_reset", sout, 0);

        do_ld(8'h81); do_seq(3'd0, 4'd3, 8'h00, 0);
        check("plan_sll", pout, 8'h08);
        do_ld(8'h81); do_seq(3'd2, 4'd2, 8'h00, 0);
        check("plan_sra", pout, 8'hE0);
        do_ld(8'h96); do_seq(3'd4, 4'd8, 8'h00, 0);
        check("plan_ror8", pout, 8'h96);
        do_ld(8'h96); do_seq(3'd3, 4'd12, 8'h00, 0);
        check("plan_rol_clamp", pout, 8'h96);
        do_ld(8'h96); do_seq(3'd3, 4'd1, 8'h00, 0);
        check("plan_rol1", pout, 8'h2D);
        check("plan_rol1_sout", sout, 1);
        do_ld(8'h00); do_seq(3'd6, 4'd4, 8'b0000_1101, 0);
        check("plan_sri", pout, 8'hD0);

        do_ld(8'hFF); do_abort(3'd0, 4'd6, 2, 8'h3C);

        do_ld(8'h5A); do_seq(3'd1, 4'd5, 8'h00, 1);
        idle(W + 2);

        ld = 1'b1; start = 1'b1; pin = 8'hC3; op = 3'd0; amt = 4'd3;
        @(posedge clk); #1;
        check("ldstart_pout", pout, 8'hC3);
        check("ldstart_busy", busy, 0);
        @(negedge clk);
        ld = 1'b0; start = 1'b0; mr = 8'hC3;
        idle(5);

        do_seq(3'd5, 4'd0, 8'hFF, 0);
        do_seq(3'd7, 4'd5, 8'hFF, 0);
        check("reserved_pout", pout, 8'hC3);
        do_seq(3'd3, 4'd3, 8'h00, 0);
        do_seq(3'd6, 4'd2, 8'h03, 0);
        do_seq(3'd0, 4'd0, 8'h00, 0);
        idle(2);

        do_ld(8'hE7);
        op = 3'd1; amt = 4'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_pout", pout, 0);
        check("midrst_sout", sout, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1; mr = '0; ms = 1'b0;
        idle(W + 2);
        check("post_rst_busy", busy, 0);

        for (int it = 0; it < 80; it++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act == 0) do_ld(W'($urandom));
            else if (act == 1) idle($urandom_range(1, 3));
            else do_seq(3'($urandom), AW'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
        end

        idle(3);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
